// File: rtl/cbfp_pkg.sv
// Shared types and default sizing for the complex block-floating-point converter.
package cbfp_pkg;

    localparam int IN_WIDTH_DEF  = 16;
    localparam int OUT_WIDTH_DEF = 10;
    localparam int EXP_WIDTH_DEF = 4;
    localparam int BLOCK_LEN_DEF = 8;

    localparam int EMAX    = IN_WIDTH_DEF - OUT_WIDTH_DEF;
    localparam int ADDR_W  = $clog2(BLOCK_LEN_DEF);
    localparam int ENTRY_W = 2 * IN_WIDTH_DEF + EXP_WIDTH_DEF;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_DRAIN
    } rd_state_t;

    // Buffer entry layout is {i, q, exp}; sized here so overridden widths stay consistent.
    function automatic int entry_width(input int in_w, input int exp_w);
        return 2 * in_w + exp_w;
    endfunction

endpackage

// File: rtl/complex_exp_detect.sv
// Combinational complex exponent: max of the I and Q leading-sign-scan exponents.
module complex_exp_detect #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 10,
    parameter int EXP_WIDTH = 4
) (
    input  logic [IN_WIDTH-1:0]  sample_i,
    input  logic [IN_WIDTH-1:0]  sample_q,
    output logic [EXP_WIDTH-1:0] cexp
);

    // The highest bit in [OUT_WIDTH-1, IN_WIDTH-2] that differs from the sign
    // sets how far the value must shift to fit the output mantissa.
    function automatic logic [EXP_WIDTH-1:0] sign_scan(input logic [IN_WIDTH-1:0] v);
        logic [EXP_WIDTH-1:0] e;
        e = '0;
        for (int j = OUT_WIDTH - 1; j <= IN_WIDTH - 2; j++) begin
            if (v[j] != v[IN_WIDTH-1]) e = EXP_WIDTH'(j - OUT_WIDTH + 2);
        end
        return e;
    endfunction

    logic [EXP_WIDTH-1:0] exp_i;
    logic [EXP_WIDTH-1:0] exp_q;

    assign exp_i = sign_scan(sample_i);
    assign exp_q = sign_scan(sample_q);
    assign cexp  = (exp_i > exp_q) ? exp_i : exp_q;

endmodule

// File: rtl/complex_bfp_convert.sv
// Complex BFP converter: ping-pong sample banks, per-sample or shared block exponent,
// optional round-half-up with positive saturation, valid/ready on both sides.
module complex_bfp_convert
    import cbfp_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int EXP_WIDTH = EXP_WIDTH_DEF,
    parameter int BLOCK_LEN = BLOCK_LEN_DEF,
    parameter int ROUND_EN  = 1
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 block_mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [IN_WIDTH-1:0]  input_i,
    input  logic [IN_WIDTH-1:0]  input_q,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic [OUT_WIDTH-1:0] output_i,
    output logic [OUT_WIDTH-1:0] output_q,
    output logic [EXP_WIDTH-1:0] output_exp
);

    localparam int ADDR_BITS = $clog2(BLOCK_LEN);
    localparam int ENT_W     = entry_width(IN_WIDTH, EXP_WIDTH);
    localparam int DEPTH     = 2 * BLOCK_LEN;

    localparam logic signed [IN_WIDTH:0] SAT_WIDE = (IN_WIDTH + 1)'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic [OUT_WIDTH-1:0]     SAT_OUT  = OUT_WIDTH'(2 ** (OUT_WIDTH - 1) - 1);

    bank_state_t          bank_st   [2];
    logic [ADDR_BITS:0]   bank_len  [2];
    logic                 bank_mode [2];
    logic [EXP_WIDTH-1:0] bank_max  [2];
    logic [ENT_W-1:0]     mem       [DEPTH];

    logic                 wr_bank;
    logic [ADDR_BITS-1:0] wr_cnt;
    logic                 rd_bank;
    logic [ADDR_BITS-1:0] rd_cnt;
    rd_state_t            rd_state;
    logic                 ready_en;

    logic [EXP_WIDTH-1:0] smp_exp;

    complex_exp_detect #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .EXP_WIDTH(EXP_WIDTH)
    ) u_exp_detect (
        .sample_i(input_i),
        .sample_q(input_q),
        .cexp    (smp_exp)
    );

    // in_ready stays low through reset and rises on the first clock after release.
    assign in_ready = ready_en &&
                      (bank_st[wr_bank] == BANK_EMPTY || bank_st[wr_bank] == BANK_FILLING);

    logic                 accept;
    logic                 close;
    logic [EXP_WIDTH-1:0] new_max;

    assign accept  = in_valid && in_ready;
    assign close   = accept && (in_last || wr_cnt == ADDR_BITS'(BLOCK_LEN - 1));
    assign new_max = (wr_cnt == '0 || smp_exp > bank_max[wr_bank]) ? smp_exp : bank_max[wr_bank];

    // Round-half-up on a one-bit-wider sum, then arithmetic shift; only positive
    // values can round past the mantissa range.
    function automatic logic [OUT_WIDTH-1:0] scale(input logic signed [IN_WIDTH-1:0] v,
                                                   input logic [EXP_WIDTH-1:0] e);
        logic signed [IN_WIDTH:0] sum;
        logic signed [IN_WIDTH:0] shifted;
        sum = {v[IN_WIDTH-1], v};
        if (ROUND_EN != 0 && e != '0) sum = sum + ((IN_WIDTH + 1)'(1) << (e - EXP_WIDTH'(1)));
        shifted = sum >>> e;
        if (shifted > SAT_WIDE) return SAT_OUT;
        return shifted[OUT_WIDTH-1:0];
    endfunction

    logic                 rel;
    logic                 advance;
    logic                 start;
    logic                 switch_bank;
    logic                 ld_bank;
    logic [ADDR_BITS-1:0] ld_idx;
    logic [ENT_W-1:0]     entry;
    logic [EXP_WIDTH-1:0] exp_use;
    logic                 ld_last;
    logic [OUT_WIDTH-1:0] ld_i;
    logic [OUT_WIDTH-1:0] ld_q;

    // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
    always_comb begin
        rel         = rd_state == RD_DRAIN && out_valid && out_ready && out_last;
        advance     = rd_state == RD_DRAIN && out_valid && out_ready && !out_last;
        start       = rd_state == RD_IDLE && bank_st[rd_bank] == BANK_FULL;
        switch_bank = rel && bank_st[~rd_bank] == BANK_FULL;
        ld_bank     = rel ? ~rd_bank : rd_bank;
        ld_idx      = advance ? rd_cnt : '0;
        entry       = mem[{ld_bank, ld_idx}];
        exp_use     = bank_mode[ld_bank] ? bank_max[ld_bank] : entry[EXP_WIDTH-1:0];
        ld_last     = {1'b0, ld_idx} == bank_len[ld_bank] - (ADDR_BITS + 1)'(1);
        ld_i        = scale($signed(entry[ENT_W-1 -: IN_WIDTH]), exp_use);
        ld_q        = scale($signed(entry[EXP_WIDTH +: IN_WIDTH]), exp_use);
    end

    // NOTE: sample storage has no reset; bank states gate every read, so stale entries never reach the output.
    always_ff @(posedge clk) begin
        if (accept) mem[{wr_bank, wr_cnt}] <= {input_i, input_q, smp_exp};
    end

    // Write side and read FSM share one block because both advance the bank states;
    // they never touch the same bank in the same cycle.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int b = 0; b < 2; b++) begin
                bank_st[b]   <= BANK_EMPTY;
                bank_len[b]  <= '0;
                bank_mode[b] <= 1'b0;
                bank_max[b]  <= '0;
            end
            wr_bank    <= 1'b0;
            wr_cnt     <= '0;
            rd_bank    <= 1'b0;
            rd_cnt     <= '0;
            rd_state   <= RD_IDLE;
            ready_en   <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            output_i   <= '0;
            output_q   <= '0;
            output_exp <= '0;
        end else begin
            ready_en <= 1'b1;

            if (accept) begin
                if (wr_cnt == '0) bank_mode[wr_bank] <= block_mode;
                bank_max[wr_bank] <= new_max;
                if (close) begin
                    bank_st[wr_bank]  <= BANK_FULL;
                    bank_len[wr_bank] <= {1'b0, wr_cnt} + (ADDR_BITS + 1)'(1);
                    wr_cnt            <= '0;
                    wr_bank           <= ~wr_bank;
                end else begin
                    bank_st[wr_bank] <= BANK_FILLING;
                    wr_cnt           <= wr_cnt + ADDR_BITS'(1);
                end
            end

            case (rd_state)
                RD_IDLE: begin
                    if (start) begin
                        bank_st[rd_bank] <= BANK_DRAINING;
                        rd_cnt           <= ADDR_BITS'(1);
                        rd_state         <= RD_DRAIN;
                        out_valid        <= 1'b1;
                        out_last         <= ld_last;
                        output_i         <= ld_i;
                        output_q         <= ld_q;
                        output_exp       <= exp_use;
                    end
                end
                RD_DRAIN: begin
                    if (rel) begin
                        bank_st[rd_bank] <= BANK_EMPTY;
                        rd_bank          <= ~rd_bank;
                        if (switch_bank) begin
                            bank_st[~rd_bank] <= BANK_DRAINING;
                            rd_cnt            <= ADDR_BITS'(1);
                            out_last          <= ld_last;
                            output_i          <= ld_i;
                            output_q          <= ld_q;
                            output_exp        <= exp_use;
                        end else begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            rd_state  <= RD_IDLE;
                        end
                    end else if (advance) begin
                        rd_cnt     <= rd_cnt + ADDR_BITS'(1);
                        out_last   <= ld_last;
                        output_i   <= ld_i;
                        output_q   <= ld_q;
                        output_exp <= exp_use;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_complex_bfp_convert.sv
// Directed bench for complex_bfp_convert; a truncating instance shares the stimulus.
module tb_complex_bfp_convert;

    localparam int IN_WIDTH  = 16;
    localparam int OUT_WIDTH = 10;
    localparam int EXP_WIDTH = 4;
    localparam int BLOCK_LEN = 8;

    logic                 clk = 1'b0;
    logic                 rst_b = 1'b0;
    logic                 block_mode = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_last = 1'b0;
    logic [IN_WIDTH-1:0]  input_i = '0;
    logic [IN_WIDTH-1:0]  input_q = '0;
    logic                 out_ready = 1'b1;

    logic                 in_ready, out_valid, out_last;
    logic [OUT_WIDTH-1:0] output_i, output_q;
    logic [EXP_WIDTH-1:0] output_exp;

    logic                 t_in_ready, t_out_valid, t_out_last;
    logic [OUT_WIDTH-1:0] t_output_i, t_output_q;
    logic [EXP_WIDTH-1:0] t_output_exp;

    always #5 clk = ~clk;

    complex_bfp_convert #(
        .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .EXP_WIDTH(EXP_WIDTH),
        .BLOCK_LEN(BLOCK_LEN), .ROUND_EN(1)
    ) dut (
        .clk(clk), .rst_b(rst_b), .block_mode(block_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .input_i(input_i), .input_q(input_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .output_i(output_i), .output_q(output_q), .output_exp(output_exp)
    );

    complex_bfp_convert #(
        .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .EXP_WIDTH(EXP_WIDTH),
        .BLOCK_LEN(BLOCK_LEN), .ROUND_EN(0)
    ) dut_trunc (
        .clk(clk), .rst_b(rst_b), .block_mode(block_mode),
        .in_valid(in_valid), .in_ready(t_in_ready), .in_last(in_last),
        .input_i(input_i), .input_q(input_q),
        .out_valid(t_out_valid), .out_ready(out_ready), .out_last(t_out_last),
        .output_i(t_output_i), .output_q(t_output_q), .output_exp(t_output_exp)
    );

    typedef struct {
        int i;
        int q;
        int e;
        int last;
        int ti;
        int cyc;
    } obs_t;

    obs_t out_q[$];
    int   cycle    = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge clk) cycle++;

    always @(negedge clk) begin
        obs_t o;
        if (rst_b && out_valid && out_ready) begin
            o.i    = int'($signed(output_i));
            o.q    = int'($signed(output_q));
            o.e    = int'(output_exp);
            o.last = int'(out_last);
            o.ti   = int'($signed(t_output_i));
            o.cyc  = cycle;
            out_q.push_back(o);
        end
    end

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Called one step after a rising edge; returns at the same phase after the transfer.
    task automatic send(input int i, input int q, input logic last, input logic mode);
        int budget = 0;
        in_valid   = 1'b1;
        input_i    = i[IN_WIDTH-1:0];
        input_q    = q[IN_WIDTH-1:0];
        in_last    = last;
        block_mode = mode;
        @(negedge clk);
        while (!in_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) check("send_ready", int'(in_ready), 1);
        align();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_outputs(input int n);
        int budget = 0;
        while (out_q.size() < n && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check("out_count", out_q.size(), n);
        align();
    endtask

    task automatic expect_out(input string tag, input int ei, input int eq, input int ee,
                              input int el);
        obs_t o;
        if (out_q.size() == 0) begin
            check({tag, "_present"}, out_q.size(), 1);
            return;
        end
        o = out_q.pop_front();
        check({tag, "_i"}, o.i, ei);
        check({tag, "_q"}, o.q, eq);
        check({tag, "_exp"}, o.e, ee);
        check({tag, "_last"}, o.last, el);
    endtask

    initial begin
        obs_t o;
        int   acc;
        int   first_cyc;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_output_exp", int'(output_exp), 0);
        #3 rst_b = 1'b1;
        align();
        check("post_rst_in_ready", int'(in_ready), 1);
        check("post_rst_out_valid", int'(out_valid), 0);

        // Saturation after rounding, per-sample exponent
        send(32'h7FFF, 1, 1'b1, 1'b0);
        wait_outputs(1);
        o = out_q[0];
        check("sat_trunc_i", o.ti, 511);
        expect_out("sat", 511, 0, 6, 1);

        // Shared block exponent over a full block
        for (int k = 0; k < BLOCK_LEN; k++) send(k * 100, 0, 1'b0, 1'b1);
        wait_outputs(BLOCK_LEN);
        for (int k = 0; k < BLOCK_LEN; k++)
            expect_out($sformatf("blk%0d", k), k * 50, 0, 1, (k == BLOCK_LEN - 1) ? 1 : 0);

        // Short block via in_last, then an independent single-sample block
        send(4, 0, 1'b0, 1'b1);
        send(8, 0, 1'b0, 1'b1);
        send(2000, 0, 1'b1, 1'b1);
        send(10, 0, 1'b1, 1'b1);
        wait_outputs(4);
        expect_out("short0", 1, 0, 2, 0);
        expect_out("short1", 2, 0, 2, 0);
        expect_out("short2", 500, 0, 2, 1);
        expect_out("single", 10, 0, 0, 1);

        // Negative boundary, rounding vs truncation
        send(-512, 0, 1'b1, 1'b0);
        send(-513, 0, 1'b1, 1'b0);
        wait_outputs(2);
        o = out_q[0];
        check("neg512_trunc_i", o.ti, -512);
        expect_out("neg512", -512, 0, 0, 1);
        o = out_q[0];
        check("neg513_trunc_i", o.ti, -257);
        expect_out("neg513", -256, 0, 1, 1);

        // Backpressure: both banks fill, then input stalls
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 30; c++) begin
            in_valid   = 1'b1;
            in_last    = 1'b0;
            block_mode = 1'b0;
            input_i    = IN_WIDTH'(acc * 3 + 5);
            input_q    = '0;
            @(negedge clk);
            if (in_ready) acc++;
            align();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_accepted", acc, 2 * BLOCK_LEN);
        check("bp_in_ready", int'(in_ready), 0);
        check("bp_hold_valid", int'(out_valid), 1);
        check("bp_hold_i", int'($signed(output_i)), 5);
        check("bp_no_transfer", out_q.size(), 0);
        align();
        out_ready = 1'b1;
        wait_outputs(2 * BLOCK_LEN);
        first_cyc = (out_q.size() > 0) ? out_q[0].cyc : 0;
        if (out_q.size() == 2 * BLOCK_LEN)
            check("bp_back_to_back", out_q[2 * BLOCK_LEN - 1].cyc - first_cyc, 2 * BLOCK_LEN - 1);
        for (int k = 0; k < 2 * BLOCK_LEN; k++)
            expect_out($sformatf("bp%0d", k), k * 3 + 5, 0, 0,
                       (k == BLOCK_LEN - 1 || k == 2 * BLOCK_LEN - 1) ? 1 : 0);

        // Reset in the middle of a drain
        out_ready = 1'b0;
        for (int k = 0; k < BLOCK_LEN; k++) send(7, 7, 1'b0, 1'b0);
        acc = 0;
        while (!out_valid && acc < 20) begin
            @(negedge clk);
            acc++;
        end
        check("drain_valid", int'(out_valid), 1);
        #3 rst_b = 1'b0;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_in_ready", int'(in_ready), 0);
        check("mid_rst_output_i", int'(output_i), 0);
        #20 rst_b = 1'b1;
        align();
        check("mid_post_in_ready", int'(in_ready), 1);
        out_ready = 1'b1;
        repeat (12) @(negedge clk);
        check("no_stale_count", out_q.size(), 0);
        check("no_stale_valid", int'(out_valid), 0);
        align();
        send(123, -4, 1'b1, 1'b0);
        wait_outputs(1);
        expect_out("post_rst", 123, -4, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/complex_bfp_convert.md
Name: complex_bfp_convert

Overview:
Parametrised complex block-floating-point converter for the acquire engine. It accepts IN_WIDTH signed I/Q samples and emits OUT_WIDTH mantissas plus an exponent, through a ping-pong sample buffer with valid/ready handshakes. Two modes are supported: per-sample exponent, or one shared exponent per block (the maximum over the block). It replaces fixed 16-to-10 truncating conversion with optional rounding, saturation and variable-length blocks.

Parameters:
IN_WIDTH, 16, input I/Q width (signed two's complement)
OUT_WIDTH, 10, output mantissa width (signed)
EXP_WIDTH, 4, exponent width; must satisfy 2^EXP_WIDTH > IN_WIDTH-OUT_WIDTH
BLOCK_LEN, 8, samples per bank, power of 2, >=2
ROUND_EN, 1, 1 = round half up before shifting; 0 = truncate (arithmetic shift)

Ports:
clk  in  1  clock
rst_b  in  1  asynchronous active-low reset
block_mode  in  1  0 = per-sample exponent, 1 = shared block exponent; sampled on the first accepted sample of each bank
in_valid  in  1  input sample valid
in_ready  out  1  converter can accept a sample
in_last  in  1  closes the current block early (with an accepted sample)
input_i  in  IN_WIDTH  I sample
input_q  in  IN_WIDTH  Q sample
out_valid  out  1  output valid
out_ready  in  1  downstream accepts the output
out_last  out  1  final sample of a block
output_i  out  OUT_WIDTH  I mantissa
output_q  out  OUT_WIDTH  Q mantissa
output_exp  out  EXP_WIDTH  exponent; value = mantissa * 2^exp

Behaviour:
- Reset (rst_b low, asynchronous): in_ready=0 while asserted and 1 the first cycle after release; out_valid=0, out_last=0, output_i/q/exp=0. Both banks are EMPTY; counters and max registers are 0. Reset mid-block discards all buffered data.
- Exponent of a value v is the smallest e in 0..EMAX (EMAX=IN_WIDTH-OUT_WIDTH) such that v>>>e lies in [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. The complex exponent is max(e_i, e_q). Detection is a leading-sign scan of the top EMAX+1 bits.
- Accept: a sample transfers when in_valid && in_ready.
  - Writes into the current write bank at index wr_cnt.
  - Stores its own complex exponent with the sample.
  - Updates the bank running max.
- A bank closes when wr_cnt reaches BLOCK_LEN-1 or in_last is set on the transfer. The closed bank records its length (1..BLOCK_LEN), mode and max exponent, becomes FULL, and writing moves to the other bank.
- Bank states: EMPTY -> FILLING (first write) -> FULL (close) -> DRAINING (read side selects it) -> EMPTY (last output accepted).
- in_ready = current write bank is EMPTY or FILLING.
- Read FSM states are IDLE and DRAIN.
  - IDLE -> DRAIN when the oldest bank is FULL.
  - DRAIN presents samples in write order.
  - After the last sample is accepted, the FSM goes to the other bank if it is FULL (no bubble), otherwise to IDLE.
- Outputs are registered:
  - out_valid rises the cycle after the bank closes (minimum latency: 1 cycle after the last accepted sample).
  - All outputs hold stable while out_valid && !out_ready.
- Shift: exp_use = bank max if the bank mode is 1, else the stored per-sample exponent. output_exp = exp_use.
  - ROUND_EN=1: the result is (v + 2^(exp_use-1)) >>> exp_use; no addend when exp_use=0. If the result exceeds 2^(OUT_WIDTH-1)-1, it saturates to 2^(OUT_WIDTH-1)-1. Negative values cannot overflow.
  - Intermediate sum is IN_WIDTH+1 bits.
- out_last=1 on the final sample of each block, including blocks closed by in_last.
- Throughput: sustained 1 sample/cycle while out_ready=1. With out_ready=0, exactly 2*BLOCK_LEN samples are accepted before in_ready drops.
- Simultaneous events in the same cycle:
  - Write-bank close and read-bank release are both honoured.
  - A bank freed this cycle becomes writable (in_ready) next cycle.
- block_mode changes mid-bank have no effect until the next bank starts.

Decomposition:
- Package cbfp_pkg holds: EMAX, ADDR_W=$clog2(BLOCK_LEN), the bank state enum (EMPTY/FILLING/FULL/DRAINING), the read FSM enum, and the entry width 2*IN_WIDTH+EXP_WIDTH.
- One sub-module, complex_exp_detect (combinational, parametrised IN_WIDTH/OUT_WIDTH), returns the per-sample complex exponent. It is instantiated on the write side.
- Buffer storage is inline as a 2*BLOCK_LEN-entry register array.

Test Plan:
1. Sample mode, ROUND_EN=1: I=0x7FFF, Q=0x0001, in_last=1 -> exp=6, output_i=511 (saturated from 512), output_q=0, out_last=1.
2. Block mode, BLOCK_LEN=8: I=0,100,...,700, Q=0 -> all outputs have exp=1; I outputs are 0,50,...,350; out_last only on the 8th.
3. Block mode, in_last on the 3rd sample (I=4,8,2000) -> 3 outputs with exp=2: 1,2,500; out_last on the 3rd. The next block's exponent is independent (I=10 alone -> exp 0).
4. Negative boundary: I=-512 -> exp 0, out -512. I=-513 -> exp 1, out -256 (round half up). ROUND_EN=0 gives -257.
5. Backpressure: continuous in_valid with out_ready=0 for 30 cycles -> exactly 16 samples accepted, in_ready=0. After release, all 16 arrive in order with no loss, then 1 sample/cycle steady state.
6. Assert rst_b mid-DRAIN -> out_valid=0 immediately (asynchronously). After release: in_ready=1, no stale samples emitted.
